// File: rtl/ex_muldiv_stage_pkg.sv
// rtl/ex_muldiv_stage_pkg.sv - shared encodings for the EX stage and its iterative mul/div unit
package ex_muldiv_stage_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_NOP         = 3'd0,
    SEL_LOGIC       = 3'd1,
    SEL_SHIFT       = 3'd2,
    SEL_ARITH       = 3'd3,
    SEL_MULDIV      = 3'd4,
    SEL_JUMP_BRANCH = 3'd5,
    SEL_MEM         = 3'd6
  } alusel_e;

  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_SLL    = 8'h04;
  localparam logic [7:0] OP_SRL    = 8'h05;
  localparam logic [7:0] OP_SRA    = 8'h06;
  localparam logic [7:0] OP_ADD    = 8'h07;
  localparam logic [7:0] OP_SUB    = 8'h08;
  localparam logic [7:0] OP_SLT    = 8'h09;
  localparam logic [7:0] OP_SLTU   = 8'h0A;
  localparam logic [7:0] OP_BEQ    = 8'h10;
  localparam logic [7:0] OP_BNE    = 8'h11;
  localparam logic [7:0] OP_BLT    = 8'h12;
  localparam logic [7:0] OP_BGE    = 8'h13;
  localparam logic [7:0] OP_BLTU   = 8'h14;
  localparam logic [7:0] OP_BGEU   = 8'h15;
  localparam logic [7:0] OP_JAL    = 8'h16;
  localparam logic [7:0] OP_JALR   = 8'h17;
  localparam logic [7:0] OP_LW     = 8'h20;
  localparam logic [7:0] OP_SW     = 8'h21;
  localparam logic [7:0] OP_MUL    = 8'h30;
  localparam logic [7:0] OP_MULH   = 8'h31;
  localparam logic [7:0] OP_MULHSU = 8'h32;
  localparam logic [7:0] OP_MULHU  = 8'h33;
  localparam logic [7:0] OP_DIV    = 8'h34;
  localparam logic [7:0] OP_DIVU   = 8'h35;
  localparam logic [7:0] OP_REM    = 8'h36;
  localparam logic [7:0] OP_REMU   = 8'h37;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - radix-2 shift-add multiplier / restoring divider with start/busy/done
module ex_muldiv
  import ex_muldiv_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state_q, state_nxt;
  logic        load, step;
  logic [4:0]  count_q;
  logic [7:0]  op_q;
  logic [63:0] acc_q;      // mul: {hi, lo} product; div: {remainder, quotient}
  logic [31:0] b_q;
  logic        neg_res_q, neg_rem_q;

  logic        a_neg, b_neg, div_zero, div_ovf, special;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_sub;
  logic [63:0] mul_next, div_next, prod;

  assign a_neg    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM) ? a[31] : 1'b0;
  assign b_neg    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM) ? b[31] : 1'b0;
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = !is_mul_op(op) && (b == ZeroWord);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_sub   = div_shift[31:0] - b_q;
  assign div_next  = (div_shift >= {1'b0, b_q}) ? {div_sub, acc_q[30:0], 1'b1}
                                                : {div_shift[31:0], acc_q[30:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= MD_IDLE;
    else                  state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      MD_IDLE: if (start) begin
        busy      = 1'b1;
        load      = 1'b1;
        state_nxt = special ? MD_DONE : MD_BUSY;
      end
      MD_BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (count_q == 5'd31) state_nxt = MD_DONE;
      end
      MD_DONE: begin
        done      = 1'b1;
        state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
    if (rst == RstEnable) busy = 1'b0;
  end

  // Special cases preload their final answer so DONE needs no extra path.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_q   <= 5'd0;
      op_q      <= 8'd0;
      acc_q     <= 64'd0;
      b_q       <= ZeroWord;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (load) begin
      count_q <= 5'd0;
      op_q    <= op;
      if (special) begin
        acc_q     <= div_zero ? {a, 32'hFFFF_FFFF} : {ZeroWord, 32'h8000_0000};
        b_q       <= ZeroWord;
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end else begin
        acc_q     <= {ZeroWord, a_mag};
        b_q       <= b_mag;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
      end
    end else if (step) begin
      count_q <= count_q + 5'd1;
      acc_q   <= is_mul_op(op_q) ? mul_next : div_next;
    end
  end

  assign prod = neg_res_q ? -acc_q : acc_q;

  always_comb begin
    result = ZeroWord;
    case (op_q)
      OP_MUL:                        result = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[63:32];
      OP_DIV, OP_DIVU:               result = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
      OP_REM, OP_REMU:               result = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
      default:                       result = ZeroWord;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - execute stage: single-cycle ALU/branch/address plus iterative mul/div
module ex_muldiv_stage
  import ex_muldiv_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_pc_i,
  input  logic [31:0] branch_offset_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [7:0]  aluop_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        branch_flag_o,
  output logic [31:0] branch_target_o,
  output logic        stall_req_o
);

  logic        md_busy, md_done;
  logic [31:0] md_result;
  logic [4:0]  shamt;

  assign shamt = reg2_i[4:0];

  ex_muldiv u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (alusel_i == SEL_MULDIV),
    .op     (aluop_i),
    .a      (reg1_i),
    .b      (reg2_i),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign stall_req_o = md_busy;

  always_comb begin
    wd_o            = wd_i;
    aluop_o         = aluop_i;
    wreg_o          = wreg_i;
    wdata_o         = ZeroWord;
    mem_addr_o      = ZeroWord;
    mem_data_o      = ZeroWord;
    branch_flag_o   = 1'b0;
    branch_target_o = link_pc_i - 32'd4 + branch_offset_i;
    case (alusel_i)
      SEL_LOGIC: case (aluop_i)
        OP_AND:  wdata_o = reg1_i & reg2_i;
        OP_OR:   wdata_o = reg1_i | reg2_i;
        OP_XOR:  wdata_o = reg1_i ^ reg2_i;
        default: wdata_o = ZeroWord;
      endcase
      SEL_SHIFT: case (aluop_i)
        OP_SLL:  wdata_o = reg1_i << shamt;
        OP_SRL:  wdata_o = reg1_i >> shamt;
        OP_SRA:  wdata_o = $signed(reg1_i) >>> shamt;
        default: wdata_o = ZeroWord;
      endcase
      SEL_ARITH: case (aluop_i)
        OP_ADD:  wdata_o = reg1_i + reg2_i;
        OP_SUB:  wdata_o = reg1_i - reg2_i;
        OP_SLT:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
        OP_SLTU: wdata_o = {31'd0, reg1_i < reg2_i};
        default: wdata_o = ZeroWord;
      endcase
      SEL_JUMP_BRANCH: case (aluop_i)
        OP_BEQ:  branch_flag_o = reg1_i == reg2_i;
        OP_BNE:  branch_flag_o = reg1_i != reg2_i;
        OP_BLT:  branch_flag_o = $signed(reg1_i) < $signed(reg2_i);
        OP_BGE:  branch_flag_o = $signed(reg1_i) >= $signed(reg2_i);
        OP_BLTU: branch_flag_o = reg1_i < reg2_i;
        OP_BGEU: branch_flag_o = reg1_i >= reg2_i;
        OP_JAL: begin
          branch_flag_o = 1'b1;
          wdata_o       = link_pc_i;
        end
        OP_JALR: begin
          branch_flag_o   = 1'b1;
          wdata_o         = link_pc_i;
          branch_target_o = (reg1_i + branch_offset_i) & ~32'd1;
        end
        default: branch_flag_o = 1'b0;
      endcase
      SEL_MEM: begin
        mem_addr_o = reg1_i + branch_offset_i;
        mem_data_o = reg2_i;
      end
      // Only the DONE cycle carries a real result into EX/MEM.
      SEL_MULDIV: begin
        wreg_o  = wreg_i & md_done;
        wdata_o = md_done ? md_result : ZeroWord;
      end
      default: wreg_o = 1'b0;
    endcase
    if (rst == RstEnable) begin
      wreg_o        = 1'b0;
      wdata_o       = ZeroWord;
      branch_flag_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - scoreboard bench for ex_muldiv_stage
module tb_ex_muldiv_stage;
  import ex_muldiv_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = 8'd0;
  logic [2:0]  alusel_i = 3'd0;
  logic [31:0] reg1_i = '0, reg2_i = '0, link_pc_i = '0, branch_offset_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, branch_flag_o, stall_req_o;
  logic [31:0] wdata_o, mem_addr_o, mem_data_o, branch_target_o;
  logic [7:0]  aluop_o;

  always #5 clk = ~clk;

  ex_muldiv_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .link_pc_i(link_pc_i), .branch_offset_i(branch_offset_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .aluop_o(aluop_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .branch_flag_o(branch_flag_o), .branch_target_o(branch_target_o),
    .stall_req_o(stall_req_o)
  );

  typedef struct {
    string       name;
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  wd;
    logic [7:0]  op;
    logic        flag;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic        chk_mem;
    logic [31:0] maddr;
    logic [31:0] mdata;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic tb_valid = 1'b0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] sel, input logic [7:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] off,
                                 input logic wr, input logic [4:0] wd);
    exp_t        e;
    longint      ps;
    logic [63:0] pu;
    int          ia, ib;
    e.name = ""; e.wdata = 0; e.wreg = wr; e.wd = wd; e.op = op; e.flag = 0;
    e.chk_tgt = 0; e.tgt = 0; e.chk_mem = 0; e.maddr = 0; e.mdata = 0; e.stalls = 0;
    ia = int'(a); ib = int'(b);
    case (sel)
      SEL_NOP: e.wreg = 1'b0;
      SEL_LOGIC: e.wdata = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
      SEL_SHIFT: begin
        if (op == OP_SLL)      e.wdata = a << b[4:0];
        else if (op == OP_SRL) e.wdata = a >> b[4:0];
        else                   e.wdata = 32'(ia >>> b[4:0]);
      end
      SEL_ARITH: case (op)
        OP_ADD:  e.wdata = a + b;
        OP_SUB:  e.wdata = a - b;
        OP_SLT:  e.wdata = (ia < ib) ? 32'd1 : 32'd0;
        default: e.wdata = (a < b) ? 32'd1 : 32'd0;
      endcase
      SEL_JUMP_BRANCH: begin
        e.chk_tgt = 1'b1;
        e.tgt = pc - 4 + off;
        case (op)
          OP_BEQ:  e.flag = (a == b);
          OP_BNE:  e.flag = (a != b);
          OP_BLT:  e.flag = (ia < ib);
          OP_BGE:  e.flag = (ia >= ib);
          OP_BLTU: e.flag = (a < b);
          OP_BGEU: e.flag = (a >= b);
          OP_JAL:  begin e.flag = 1; e.wdata = pc; end
          default: begin e.flag = 1; e.wdata = pc; e.tgt = (a + off) & 32'hFFFF_FFFE; end
        endcase
      end
      SEL_MEM: begin
        e.chk_mem = 1'b1; e.maddr = a + off; e.mdata = b;
      end
      default: begin
        e.stalls = 33;
        case (op)
          OP_MUL:    e.wdata = a * b;
          OP_MULH:   begin ps = longint'(ia) * longint'(ib); e.wdata = ps[63:32]; end
          OP_MULHSU: begin ps = longint'(ia) * longint'({32'd0, b}); e.wdata = ps[63:32]; end
          OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; e.wdata = pu[63:32]; end
          default: begin
            if (b == 0) begin
              e.stalls = 1;
              e.wdata = (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
            end else if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              e.stalls = 1;
              e.wdata = (op == OP_DIV) ? 32'h8000_0000 : 32'd0;
            end else case (op)
              OP_DIV:  e.wdata = 32'(ia / ib);
              OP_REM:  e.wdata = 32'(ia % ib);
              OP_DIVU: e.wdata = a / b;
              default: e.wdata = a % b;
            endcase
          end
        endcase
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (tb_valid && !rst) begin
      if (stall_req_o) stall_cnt++;
      else begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard: output with no expected entry");
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, " wdata"}, wdata_o, mon_e.wdata);
          chk({mon_e.name, " wreg"}, {31'd0, wreg_o}, {31'd0, mon_e.wreg});
          chk({mon_e.name, " wd"}, {27'd0, wd_o}, {27'd0, mon_e.wd});
          chk({mon_e.name, " aluop"}, {24'd0, aluop_o}, {24'd0, mon_e.op});
          chk({mon_e.name, " flag"}, {31'd0, branch_flag_o}, {31'd0, mon_e.flag});
          chk({mon_e.name, " stalls"}, stall_cnt, mon_e.stalls);
          if (mon_e.chk_tgt) chk({mon_e.name, " target"}, branch_target_o, mon_e.tgt);
          if (mon_e.chk_mem) begin
            chk({mon_e.name, " mem_addr"}, mem_addr_o, mon_e.maddr);
            chk({mon_e.name, " mem_data"}, mem_data_o, mon_e.mdata);
          end
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] off,
                       input logic wr, input logic [4:0] wd, input string name);
    exp_t e;
    int   n;
    e = model(sel, op, a, b, pc, off, wr, wd);
    e.name = name;
    sb.push_back(e);
    alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b;
    link_pc_i = pc; branch_offset_i = off; wreg_i = wr; wd_i = wd;
    tb_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (stall_req_o && n < 100);
    if (stall_req_o) begin
      checks++; failures++;
      $display("FAIL %s timeout: stall still %b after %0d cycles, required 0", name, stall_req_o, n);
    end
    @(posedge clk); #1;
    tb_valid = 1'b0;
    alusel_i = SEL_NOP;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [7:0] ops_logic[3]  = '{OP_AND, OP_OR, OP_XOR};
  logic [7:0] ops_shift[3]  = '{OP_SLL, OP_SRL, OP_SRA};
  logic [7:0] ops_arith[4]  = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU};
  logic [7:0] ops_jb[8]     = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR};
  logic [7:0] ops_md[8]     = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  initial begin
    logic [31:0] prod, off, a, b;
    logic [2:0]  sel;
    logic [7:0]  op;

    rst = 1'b1;
    alusel_i = SEL_JUMP_BRANCH; aluop_i = OP_JAL; wreg_i = 1'b1; link_pc_i = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wreg", {31'd0, wreg_o}, 32'd0);
    chk("reset wdata", wdata_o, 32'd0);
    chk("reset flag", {31'd0, branch_flag_o}, 32'd0);
    alusel_i = SEL_MULDIV; aluop_i = OP_DIV; reg1_i = 32'd9; reg2_i = 32'd3;
    @(negedge clk);
    chk("reset stall", {31'd0, stall_req_o}, 32'd0);
    alusel_i = SEL_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(SEL_ARITH, OP_ADD, 32'd7, -32'sd9, 32'h0, 32'h0, 1'b1, 5'd3, "add_7_m9");
    issue(SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 1'b1, 5'd4, "sra");
    issue(SEL_JUMP_BRANCH, OP_BEQ, 32'd5, 32'd5, 32'h104, -32'sd8, 1'b0, 5'd0, "beq");
    issue(SEL_JUMP_BRANCH, OP_JALR, 32'h201, 32'd0, 32'h300, 32'd4, 1'b1, 5'd1, "jalr");
    issue(SEL_MULDIV, OP_MULH, 32'h8000_0000, 32'd2, 32'h0, 32'h0, 1'b1, 5'd5, "mulh");
    issue(SEL_MULDIV, OP_DIV, 32'd100, 32'd0, 32'h0, 32'h0, 1'b1, 5'd6, "div_by_zero");
    issue(SEL_MULDIV, OP_REM, -32'sd7, 32'd2, 32'h0, 32'h0, 1'b1, 5'd7, "rem_m7_2");
    issue(SEL_MULDIV, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 5'd8, "div_ovf");
    issue(SEL_MEM, OP_SW, 32'h1000, 32'hCAFE_F00D, 32'h0, 32'h10, 1'b0, 5'd0, "sw");
    issue(SEL_NOP, OP_ADD, 32'd3, 32'd4, 32'h0, 32'h0, 1'b1, 5'd9, "nop");

    // MUL result forwarded into a dependent ADD.
    prod = 32'd123 * 32'd456;
    issue(SEL_MULDIV, OP_MUL, 32'd123, 32'd456, 32'h0, 32'h0, 1'b1, 5'd10, "mul_fwd");
    issue(SEL_ARITH, OP_ADD, prod, 32'd10, 32'h0, 32'h0, 1'b1, 5'd11, "add_dep");

    // Reset in the middle of a DIVU.
    alusel_i = SEL_MULDIV; aluop_i = OP_DIVU; reg1_i = 32'd1000; reg2_i = 32'd7; wreg_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("divu mid busy stall", {31'd0, stall_req_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("divu reset stall", {31'd0, stall_req_o}, 32'd0);
    chk("divu reset wdata", wdata_o, 32'd0);
    rst = 1'b0;
    alusel_i = SEL_NOP;
    @(posedge clk); #1;
    issue(SEL_ARITH, OP_ADD, 32'd20, 32'd22, 32'h0, 32'h0, 1'b1, 5'd12, "add_after_rst");

    for (int i = 0; i < 60; i++) begin
      a = rnd_val(); b = rnd_val();
      off = 32'($signed(12'($urandom)));
      sel = 3'($urandom_range(0, 6));
      case (sel)
        SEL_LOGIC:       op = ops_logic[$urandom_range(0, 2)];
        SEL_SHIFT:       op = ops_shift[$urandom_range(0, 2)];
        SEL_ARITH:       op = ops_arith[$urandom_range(0, 3)];
        SEL_JUMP_BRANCH: op = ops_jb[$urandom_range(0, 7)];
        SEL_MEM:         op = OP_LW;
        SEL_MULDIV:      op = ops_md[$urandom_range(0, 7)];
        default:         op = OP_ADD;
      endcase
      issue(sel, op, a, b, $urandom, off, 1'($urandom), 5'($urandom), $sformatf("rnd%0d", i));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 clk  in  1  sole clock, all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset, compared against RstEnable.
REQ-003 aluop_i  in  8  operation code from the ID/EX register; encodings come from the shared define file.
REQ-004 alusel_i  in  3  result class from the ID/EX register: NOP, LOGIC, SHIFT, ARITH, MULDIV, JUMP_BRANCH or MEM.
REQ-005 reg1_i, reg2_i  in  32 each  source operands.
REQ-006 wd_i  in  5  destination register.
REQ-007 wreg_i  in  1  write enable.
REQ-008 link_pc_i  in  32  instruction PC+4.
REQ-009 branch_offset_i  in  32  sign-extended immediate.
REQ-010 wd_o  out  5  destination register, forwarded to EX/MEM.
REQ-011 wreg_o  out  1  write enable, forwarded to EX/MEM.
REQ-012 wdata_o  out  32  result, forwarded to EX/MEM.
REQ-013 aluop_o  out  8  operation code passed through for MEM.
REQ-014 mem_addr_o  out  32  memory address.
REQ-015 mem_data_o  out  32  store data.
REQ-016 branch_flag_o  out  1  taken branch or jump.
REQ-017 branch_target_o  out  32  redirect address.
REQ-018 stall_req_o  out  1  pipeline hold request; the controller maps it to halt_type 2'b10 for PC, IF/ID and ID/EX.

Function
REQ-019 Single-cycle ops (LOGIC, SHIFT, ARITH, JUMP_BRANCH, MEM) SHALL be combinational, with stall_req_o=0.
REQ-020 ARITH/LOGIC/SHIFT SHALL use shift amount reg2_i[4:0]; SRA sign-fills; SLT is signed and SLTU unsigned, giving 32'h0/32'h1.
REQ-021 For branches, branch_target_o SHALL be link_pc_i-4+branch_offset_i, and branch_flag_o SHALL be set per BEQ/BNE/BLT/BGE/BLTU/BGEU.
REQ-022 JAL SHALL use the REQ-021 target; JALR SHALL use target (reg1_i+branch_offset_i)&~1; both set branch_flag_o=1 and wdata_o=link_pc_i.
REQ-023 MEM ops SHALL drive mem_addr_o=reg1_i+branch_offset_i and mem_data_o=reg2_i, with wdata_o=0.
REQ-024 The MULDIV FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-025 In IDLE with alusel_i=MULDIV: stall_req_o=1 combinationally, operands and op latched, 5-bit counter cleared, next state BUSY.
REQ-026 Exception to REQ-025: divide by zero or signed overflow (-2^31 / -1) SHALL go directly to DONE.
REQ-027 BUSY SHALL do one radix-2 iteration per cycle (shift-add multiply, restoring divide) on magnitudes, with stall_req_o=1, and go to DONE after 32 iterations.
REQ-028 DONE SHALL drive stall_req_o=0 and the sign-corrected result on wdata_o; next state is always IDLE.
REQ-029 MUL-class op latency: resident 34 cycles (1 IDLE + 32 BUSY + 1 DONE).
REQ-030 DIV-class op latency: 34 cycles normally, 2 cycles for the REQ-026 special cases.
REQ-031 Multiply results: MUL = low 32 bits; MULH = signed×signed high; MULHSU = signed×unsigned high; MULHU = unsigned high.
REQ-032 Divide by zero SHALL give DIV/DIVU=32'hFFFFFFFF and REM/REMU=dividend.
REQ-033 Signed overflow SHALL give DIV=32'h80000000 and REM=0.
REQ-034 Remainder sign SHALL follow the dividend.
REQ-035 Inputs are held by ID/EX during the stall; the FSM SHALL use only latched copies, and DONE→IDLE SHALL NOT restart the same op.
REQ-036 alusel_i=NOP SHALL force wreg_o=0, wdata_o=0 and branch_flag_o=0.
REQ-037 branch_flag_o SHALL be 0 whenever alusel_i is not JUMP_BRANCH.

Reset
REQ-038 When rst=1 at a clock edge, the FSM SHALL return to IDLE, the counter and latched operands SHALL clear, and stall_req_o SHALL be 0 the following cycle, including mid-BUSY.
REQ-039 While rst=1, wreg_o=0, wdata_o=0 and branch_flag_o=0.

Structure
REQ-040 Op/sel encodings, ZeroWord, RstEnable and the MULDIV FSM state encodings SHALL live in the shared define file.
REQ-041 The iterative multiplier/divider SHALL be a sub-module, ex_muldiv, with start/busy/done handshake; the parent is combinational plus the instance.

Verification
REQ-042 ADD 7+(-9) -> wdata 32'hFFFFFFFE, stall 0.
REQ-043 SRA 32'h80000000 by 4 -> wdata 32'hF8000000.
REQ-044 BEQ 5,5 with link_pc 0x104, offset -8 -> flag 1, target 0xF8.
REQ-045 JALR with reg1 0x201, offset 4 -> target 0x204.
REQ-046 MULH 32'h80000000×2 -> stall high for 33 cycles, DONE wdata 32'hFFFFFFFF.
REQ-047 DIV 100/0 -> 2-cycle residency, wdata 32'hFFFFFFFF.
REQ-048 REM -7/2 -> wdata 32'hFFFFFFFF.
REQ-049 DIV 32'h80000000/-1 -> wdata 32'h80000000.
REQ-050 DIVU started, rst at BUSY cycle 10 -> IDLE next cycle, stall 0; a following ADD completes normally.
REQ-051 MUL followed by a dependent ADD -> ADD enters EX only after DONE, correct product used via forwarding.
